// File: rtl/reset_seq_pkg.sv
// Shared types and limits for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {HOLD, STAGE, RUN} state_t;

  localparam int MAX_CH = 16;

  // Counter width for a count range of n values, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_debounce.sv
// Two-flop synchroniser followed by a consecutive-high filter for the reset request.
module req_debounce import reset_seq_pkg::*; #(
  parameter int REQ_FILTER = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int FW = cnt_w(REQ_FILTER);

  if (REQ_FILTER < 1) begin : g_bad_filter
    $error("req_debounce: REQ_FILTER must be at least 1");
  end

  logic [1:0]    sync_pipe;
  logic [FW-1:0] cnt;

  // cnt saturates at REQ_FILTER-1; the next high sample then asserts dout.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_pipe <= '0;
      cnt       <= '0;
      dout      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], din};
      if (!sync_pipe[1]) begin
        cnt  <= '0;
        dout <= 1'b0;
      end else if (cnt == FW'(REQ_FILTER - 1)) begin
        dout <= 1'b1;
      end else begin
        cnt <= cnt + FW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset channels for HOLD_CYCLES, then releases them one by one
// every STAGE_CYCLES clocks; a filtered external request restarts the sequence.
module reset_sequencer import reset_seq_pkg::*; #(
  parameter int NUM_CH       = 4,
  parameter int HOLD_CYCLES  = 25000000,
  parameter int STAGE_CYCLES = 1000,
  parameter int REQ_FILTER   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done
);

  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int SW = cnt_w(STAGE_CYCLES);
  localparam int CW = cnt_w(NUM_CH);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("reset_sequencer: NUM_CH must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be at least 1");
  end
  if (STAGE_CYCLES < 1) begin : g_bad_stage
    $error("reset_sequencer: STAGE_CYCLES must be at least 1");
  end

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stage_cnt;
  logic [CW-1:0] ch_idx;
  logic [CW-1:0] ch_nxt;
  logic          req_f;

  req_debounce #(.REQ_FILTER(REQ_FILTER)) u_req_debounce (
    .clock (clock),
    .reset (reset),
    .din   (req),
    .dout  (req_f)
  );

  assign ch_nxt = ch_idx + CW'(1);

  // busy is kept as its own flop, set and cleared on the same edges that
  // change rst_out, so it never sees an intermediate OR of changing bits.
  always_ff @(posedge clock) begin
    if (reset || req_f) begin
      state     <= HOLD;
      rst_out   <= '1;
      busy      <= 1'b1;
      done      <= 1'b0;
      hold_cnt  <= '0;
      stage_cnt <= '0;
      ch_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        HOLD: begin
          if (hold_cnt != HW'(HOLD_CYCLES - 1)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else begin
            hold_cnt   <= '0;
            stage_cnt  <= '0;
            ch_idx     <= '0;
            rst_out[0] <= 1'b0;
            if (NUM_CH == 1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= RUN;
            end else begin
              state <= STAGE;
            end
          end
        end
        STAGE: begin
          if (stage_cnt != SW'(STAGE_CYCLES - 1)) begin
            stage_cnt <= stage_cnt + SW'(1);
          end else begin
            stage_cnt <= '0;
            ch_idx    <= ch_nxt;
            rst_out   <= rst_out & ~(CH_ONE << ch_nxt);
            if (ch_nxt == CW'(NUM_CH - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: ;
        default: begin
          state   <= HOLD;
          rst_out <= '1;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: a timing model predicts every output change of a 4-channel
// and a 1-channel sequencer; a monitor pops and compares on each observed change.
module tb_reset_sequencer;

  localparam int H = 10;
  localparam int S = 3;
  localparam int F = 4;

  typedef struct packed {
    logic [3:0] rst;
    logic       done;
    logic       busy;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req   = 1'b0;
  logic [3:0] rst_out;
  logic       busy, done;
  logic [0:0] rst_out1;
  logic       busy1, done1;

  int   cyc     = 0;
  int   started = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  ev_t  q[2][$];
  out_t pobs[2];

  reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(H), .STAGE_CYCLES(S), .REQ_FILTER(F)) u_dut (
    .clock(clock), .reset(reset), .req(req), .rst_out(rst_out), .busy(busy), .done(done)
  );

  reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(H), .STAGE_CYCLES(S), .REQ_FILTER(F)) u_dut1 (
    .clock(clock), .reset(reset), .req(req), .rst_out(rst_out1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  // Expected outputs given the edge at which HOLD was last (re)entered.
  function automatic out_t model_out(input int nch, input int c, input int t);
    out_t o;
    o.rst = '0;
    for (int k = 0; k < nch; k++) o.rst[k] = (c < t + H + k * S);
    o.done = (c == t + H + (nch - 1) * S);
    o.busy = (o.rst != 4'd0);
    return o;
  endfunction

  // Reference model: req_f at edge n is high when the req samples taken at
  // edges n-F-2 .. n-3 were all high and all came after the last reset.
  initial begin
    int   run;
    int   hd[3];
    int   t0;
    bit   reqf;
    out_t pexp[2];
    out_t o;
    run = 0;
    t0  = 0;
    for (int i = 0; i < 3; i++) hd[i] = 0;
    pexp[0] = 'x;
    pexp[1] = 'x;
    forever begin
      @(posedge clock);
      cyc++;
      reqf = (hd[2] >= F);
      if (reset) begin
        run = 0;
        for (int i = 0; i < 3; i++) hd[i] = 0;
      end else begin
        run = req ? run + 1 : 0;
        hd[2] = hd[1];
        hd[1] = hd[0];
        hd[0] = run;
      end
      if (reset || (started != 0 && reqf)) begin
        t0      = cyc;
        started = 1;
      end
      if (started != 0) begin
        for (int id = 0; id < 2; id++) begin
          o = model_out((id == 0) ? 4 : 1, cyc, t0);
          if (o !== pexp[id]) begin
            q[id].push_back('{cyc, o});
            pexp[id] = o;
          end
        end
      end
    end
  end

  task automatic chk(input int id, input out_t o);
    ev_t e;
    if (o === pobs[id]) return;
    pobs[id] = o;
    n_cmp++;
    if (q[id].size() == 0) begin
      n_bad++;
      $display("FAIL dut%0d_event: edge %0d got rst/done/busy=%b, expected no change", id, cyc, o);
    end else begin
      e = q[id].pop_front();
      if (e.cyc != cyc || e.o !== o) begin
        n_bad++;
        $display("FAIL dut%0d_event: edge %0d got rst/done/busy=%b, expected edge %0d value %b",
                 id, cyc, o, e.cyc, e.o);
      end
    end
  endtask

  initial begin
    pobs[0] = 'x;
    pobs[1] = 'x;
    forever begin
      @(negedge clock);
      if (started != 0) begin
        chk(0, {rst_out, done, busy});
        chk(1, {3'b000, rst_out1, done1, busy1});
      end
    end
  end

  task automatic step(input logic r, input logic rq);
    @(negedge clock);
    reset = r;
    req   = rq;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  initial begin
    int len;
    bit val;
    // Power-on reset, then a full sequence into RUN.
    step(1'b1, 1'b0);
    idle(30);
    // Request too short to pass the filter, then one just long enough.
    repeat (3) step(1'b0, 1'b1);
    idle(12);
    repeat (4) step(1'b0, 1'b1);
    idle(30);
    // Request landing at every point of HOLD and STAGE after a reset.
    for (int d = 1; d <= 18; d++) begin
      step(1'b1, 1'b0);
      idle(d - 1);
      repeat (4) step(1'b0, 1'b1);
      idle(28);
    end
    // Reset pulsed part-way through HOLD.
    step(1'b1, 1'b0);
    idle(7);
    step(1'b1, 1'b0);
    idle(25);
    // Long held request.
    repeat (50) step(1'b0, 1'b1);
    idle(30);
    // Random request bursts with occasional resets.
    for (int i = 0; i < 300; i++) begin
      val = 1'($urandom_range(0, 1));
      len = val ? $urandom_range(1, 8) : $urandom_range(1, 30);
      repeat (len) step(($urandom_range(0, 199) == 0), val);
    end
    idle(40);
    for (int id = 0; id < 2; id++) begin
      n_cmp++;
      if (q[id].size() != 0) begin
        n_bad++;
        $display("FAIL dut%0d_drain: %0d predicted changes never seen, expected 0", id, q[id].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
